// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 configuration sequencer
//
// Contents:
//   cfg_state_t          configuration FSM state encoding
//   COM7_ADDR            COM7 register address (holds the soft-reset bit)
//   COM7_SOFT_RESET_BIT  bit of COM7 that triggers a sensor soft reset
//   ROM_TERMINATOR       command-table end marker
//   DEFAULT_CAM_ID       SCCB write ID of the OV7670
//   is_soft_reset()      true when a {reg, value} pair resets the sensor
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } cfg_state_t;

  localparam logic [7:0]  COM7_ADDR           = 8'h12;
  localparam int          COM7_SOFT_RESET_BIT = 7;
  localparam logic [15:0] ROM_TERMINATOR      = 16'hFFFF;
  localparam logic [7:0]  DEFAULT_CAM_ID      = 8'h42;

  function automatic logic is_soft_reset(input logic [7:0] reg_addr,
                                         input logic [7:0] value);
    return (reg_addr == COM7_ADDR) && value[COM7_SOFT_RESET_BIT];
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// rtl/cfg_delay_timer.sv - loadable down-counter with a single-cycle expiry pulse
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   load_i     in   load count_i and start counting from the next cycle
//   count_i    in   number of running cycles before expiry (0 behaves as 1)
//   expired_o  out  high for exactly one cycle, the last running cycle
module cfg_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic             running_q;

  // Expiry is flagged while the count reads 1 (or 0 for a zero-length
  // load), so a load of N yields exactly N running cycles and a load of 0
  // still passes through in a single cycle.
  assign expired_o = running_q && (cnt_q <= WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (load_i) begin
      cnt_q     <= count_i;
      running_q <= 1'b1;
    end else if (running_q) begin
      if (expired_o) begin
        running_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ov7670_config_ctrl.sv
// rtl/ov7670_config_ctrl.sv - walks the OV7670 register table and issues SCCB writes
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle pulse, starts configuration (IDLE only)
//   rom_command_i     table entry {reg[15:8], value[7:0]}
//   rom_finished_i    table entry is the terminator
//   rom_advance_o     one-cycle pulse, step the table
//   sccb_req_o        write request to the SCCB master
//   sccb_id_o/reg_o/data_o  write bytes, stable while sccb_req_o is high
//   sccb_ready_i      master can accept a request
//   sccb_done_i       one-cycle pulse, transaction finished
//   sccb_nack_i       qualifies sccb_done_i: slave did not acknowledge
//   busy_o            configuration in progress
//   config_done_o     sticky, terminator reached
//   error_o           sticky, an entry was dropped after all retries
//   write_count_o     acknowledged writes, saturating
module ov7670_config_ctrl
  import ov7670_pkg::*;
#(
  parameter int         CLK_FREQ_HZ    = 25_000_000,
  parameter int         RESET_DELAY_US = 1000,
  parameter logic [7:0] CAM_ID         = DEFAULT_CAM_ID,
  parameter int         MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] rom_command_i,
  input  logic        rom_finished_i,
  output logic        rom_advance_o,
  output logic        sccb_req_o,
  output logic [7:0]  sccb_id_o,
  output logic [7:0]  sccb_reg_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_ready_i,
  input  logic        sccb_done_i,
  input  logic        sccb_nack_i,
  output logic        busy_o,
  output logic        config_done_o,
  output logic        error_o,
  output logic [7:0]  write_count_o
);

  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1_000_000 * RESET_DELAY_US;
  localparam int DELAY_W_RAW  = $clog2(DELAY_CYCLES + 1);
  localparam int DELAY_W      = (DELAY_W_RAW < 1) ? 1 : DELAY_W_RAW;
  localparam int RETRY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(DELAY_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  cfg_state_t         state_q;
  logic               settle_q;
  logic [RETRY_W-1:0] retry_q;
  logic               sccb_req_q;
  logic [7:0]         sccb_id_q;
  logic [7:0]         sccb_reg_q;
  logic [7:0]         sccb_data_q;
  logic               rom_advance_q;
  logic               busy_q;
  logic               config_done_q;
  logic               error_q;
  logic [7:0]         write_count_q;
  logic [7:0]         write_count_d;

  logic table_end;
  logic soft_reset_w;
  logic write_acked;
  logic delay_load;
  logic delay_expired;

  // The terminator is recognised from either the table flag or the raw
  // marker value, so a table that only encodes one of them still ends.
  assign table_end     = rom_finished_i | (rom_command_i == ROM_TERMINATOR);
  assign soft_reset_w  = is_soft_reset(sccb_reg_q, sccb_data_q);
  assign write_acked   = (state_q == ST_WAIT) && sccb_done_i && !sccb_nack_i;
  assign write_count_d = (write_count_q == 8'hFF) ? write_count_q
                                                  : write_count_q + 8'd1;

  // The timer is loaded on the same edge the FSM enters DELAY, so its
  // first running cycle is the first DELAY cycle.
  assign delay_load = write_acked && soft_reset_w;

  cfg_delay_timer #(
    .WIDTH (DELAY_W)
  ) u_delay_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (delay_load),
    .count_i   (DELAY_LOAD),
    .expired_o (delay_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      settle_q      <= 1'b0;
      retry_q       <= '0;
      sccb_req_q    <= 1'b0;
      sccb_id_q     <= 8'h00;
      sccb_reg_q    <= 8'h00;
      sccb_data_q   <= 8'h00;
      rom_advance_q <= 1'b0;
      busy_q        <= 1'b0;
      config_done_q <= 1'b0;
      error_q       <= 1'b0;
      write_count_q <= 8'h00;
    end else begin
      rom_advance_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q  <= ST_SETTLE;
            settle_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        // Two cycles cover the table's registered address-to-data path.
        ST_SETTLE: begin
          if (settle_q) begin
            settle_q <= 1'b0;
            state_q  <= ST_CHECK;
          end else begin
            settle_q <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (table_end) begin
            state_q       <= ST_DONE;
            busy_q        <= 1'b0;
            config_done_q <= 1'b1;
          end else begin
            sccb_id_q   <= CAM_ID;
            sccb_reg_q  <= rom_command_i[15:8];
            sccb_data_q <= rom_command_i[7:0];
            retry_q     <= '0;
            sccb_req_q  <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end

        // sccb_req_q is high for the whole ISSUE state; acceptance is the
        // first edge with ready, after which the request drops.
        ST_ISSUE: begin
          if (sccb_ready_i) begin
            sccb_req_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (sccb_done_i) begin
            if (!sccb_nack_i) begin
              write_count_q <= write_count_d;
              if (soft_reset_w) begin
                state_q <= ST_DELAY;
              end else begin
                state_q       <= ST_NEXT;
                rom_advance_q <= 1'b1;
              end
            end else if (retry_q < RETRY_MAX) begin
              retry_q    <= retry_q + RETRY_W'(1);
              sccb_req_q <= 1'b1;
              state_q    <= ST_ISSUE;
            end else begin
              error_q       <= 1'b1;
              state_q       <= ST_NEXT;
              rom_advance_q <= 1'b1;
            end
          end
        end

        ST_DELAY: begin
          if (delay_expired) begin
            state_q       <= ST_NEXT;
            rom_advance_q <= 1'b1;
          end
        end

        ST_NEXT: begin
          state_q  <= ST_SETTLE;
          settle_q <= 1'b0;
        end

        // Terminal until reset; the table cannot be rewound from here.
        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_advance_o = rom_advance_q;
  assign sccb_req_o    = sccb_req_q;
  assign sccb_id_o     = sccb_id_q;
  assign sccb_reg_o    = sccb_reg_q;
  assign sccb_data_o   = sccb_data_q;
  assign busy_o        = busy_q;
  assign config_done_o = config_done_q;
  assign error_o       = error_q;
  assign write_count_o = write_count_q;

endmodule

// File: doc/ov7670_config_ctrl.md
# ov7670_config_ctrl

Sequences the OV7670 power-up register configuration. Walks the hard-coded register command table one entry at a time, turns each 16-bit `{reg, value}` command into a 3-byte SCCB write through a separate SCCB master, and waits out the sensor soft-reset time after any COM7 reset write. Retries NACKed writes a bounded number of times. Sits between the register table and the SCCB master and reports configuration completion to the video pipeline.

## Interface
- `CLK_FREQ_HZ`, 25_000_000: clk frequency; sizes the delay counter.
- `RESET_DELAY_US`, 1000: settle time after a COM7 soft-reset write.
- `CAM_ID`, 8'h42: SCCB write ID byte.
- `MAX_RETRY`, 2: extra attempts after a NACK (total attempts = MAX_RETRY+1).
- `clk  in  1`  clock.
- `rst_n  in  1`  reset, asynchronous, active-low.
- `start  in  1`  single-cycle pulse; begins configuration; honoured only in IDLE.
- `rom_command  in  16`  table entry, `[15:8]` register, `[7:0]` value.
- `rom_finished  in  1`  high when the table entry is the 16'hFFFF terminator.
- `rom_advance  out  1`  one-cycle pulse; steps the table to the next entry.
- `sccb_req  out  1`  write request to the SCCB master.
- `sccb_id`, `sccb_reg`, `sccb_data  out  8 each`  write bytes; stable while `sccb_req`=1.
- `sccb_ready  in  1`  master idle and able to accept a request.
- `sccb_done  in  1`  one-cycle pulse; transaction complete.
- `sccb_nack  in  1`  valid only with `sccb_done`; the slave did not acknowledge.
- `busy  out  1`  configuration in progress.
- `config_done  out  1`  sticky; terminator reached.
- `error  out  1`  sticky; at least one entry was dropped after exhausting retries.
- `write_count  out  8`  number of successfully acknowledged writes.

## Operation
- States: IDLE, SETTLE, CHECK, ISSUE, WAIT, DELAY, NEXT, DONE.
- IDLE: on `start` go to SETTLE.
- SETTLE: wait exactly 2 cycles, which covers the table's registered address-to-command latency. Then go to CHECK.
- CHECK: if `rom_finished`, go to DONE. Otherwise latch `rom_command` into the byte registers, clear the retry counter, and go to ISSUE.
- ISSUE: assert `sccb_req`. On a clk edge where `sccb_req`=1 and `sccb_ready`=1, the request is accepted; `sccb_req` drops the next cycle. Then go to WAIT.
- WAIT, on `sccb_done` with no NACK:
  - Increment `write_count` (saturating at 255).
  - If `sccb_reg`==8'h12 and `sccb_data[7]`==1 (COM7 soft reset), go to DELAY; otherwise go to NEXT.
- WAIT, on `sccb_done` with NACK:
  - If retries < MAX_RETRY, increment retries and go to ISSUE with the same bytes.
  - Otherwise set `error` and go to NEXT (entry skipped).
- DELAY: count `CLK_FREQ_HZ/1_000_000*RESET_DELAY_US` cycles, then go to NEXT.
- NEXT: pulse `rom_advance` for one cycle, then go to SETTLE.
- DONE: `config_done`=1. Terminal; `start` is ignored. The table is only rewound by `rst_n`, so one configuration runs per reset.
- `busy` is 1 in every state except IDLE and DONE.
- `sccb_done` outside WAIT is ignored. `sccb_nack` without `sccb_done` is ignored.

## Timing
- Reset values: all outputs 0; byte registers 0; state IDLE.
- Latency from `start` to the first `sccb_req` is 4 cycles: start edge → SETTLE(2) → CHECK(1) → ISSUE, with `sccb_req` high in cycle 4.
- Gap from `sccb_done` (non-reset entry) to the next `sccb_req` is 5 cycles: NEXT, SETTLE×2, CHECK, ISSUE.
- `sccb_req` is held with stable bytes for any number of cycles while `sccb_ready`=0.
- `rom_advance` is never asserted in consecutive cycles and never during DELAY.
- Async reset mid-transaction: immediate return to IDLE with all outputs 0. The SCCB master is reset by the same `rst_n`.
- Delay counter width: `$clog2(delay_cycles+1)`. A delay of 0 cycles passes through DELAY in one cycle.

## Structure
- Package `ov7670_pkg`:
  - `cfg_state_t` enum.
  - `COM7_ADDR`=8'h12, `COM7_SOFT_RESET_BIT`=7.
  - `ROM_TERMINATOR`=16'hFFFF.
  - Default `CAM_ID`.
- Sub-module `cfg_delay_timer`: load and start with a cycle count, single-cycle `expired` pulse, parameterised width. It is instantiated once for the DELAY state.

## Test plan
- Reset then `start`, with a ROM model at entry 0 = 16'h1280: `sccb_req` rises 4 cycles after `start` with id/reg/data = 42/12/80; all outputs were 0 during reset.
- Soft-reset delay with `CLK_FREQ_HZ`=1_000_000, `RESET_DELAY_US`=10: after `sccb_done` for 12/80, the next `sccb_req` appears no earlier than 10 delay cycles + 5.
- Full 11-entry table (0x00–0x0A) with all ACKs: exactly 11 `rom_advance` pulses, `write_count`=11, `config_done`=1, `busy`=0, `error`=0. A further `start` produces no `sccb_req`.
- NACK on entry 3 twice, then ACK: three identical 0C/00 requests, `error`=0, `write_count` still 11 at end. Three NACKs on that entry: `error`=1, the entry is skipped, `write_count`=10.
- Hold `sccb_ready`=0 for 50 cycles while `sccb_req`=1: `sccb_req` and the bytes stay stable, no `rom_advance`, and acceptance happens on the first ready edge.
- Assert `rst_n`=0 during WAIT: all outputs are 0 immediately, state is IDLE, and a spurious `sccb_done` after reset release is ignored.
